vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the VGA sync generator: consumes the generator's hs/vs and 8-bit RGB outputs and reconstructs pixel coordinates, per-pixel data strobes, frame markers and timing measurements. Used as an on-chip loopback checker and as a capture front-end for self-test frame buffers. Runs in the 100 MHz pixel-clock domain; 640x480@60 Hz, 4 clocks per pixel.

## Interface
Parameters:
- H_TOTAL, 3200: expected clocks per line.
- V_TOTAL, 521: expected lines per frame.
- H_START, 576: clocks from hs assertion edge to first clock of pixel 0.
- V_START, 31: hs edges after vs assertion edge before row 0.
- H_ACTIVE, 640: pixels per line.
- V_ACTIVE, 480: rows per frame.
- CLKS_PER_PIXEL, 4: clocks per pixel.
- SAMPLE_PHASE, 2: clock within a pixel at which RGB is sampled (0..CLKS_PER_PIXEL-1).
- SYNC_POL, 0: active level of hs and vs.
- LOCK_FRAMES, 2: consecutive good frames required for lock.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- hs  in  1  horizontal sync.
- vs  in  1  vertical sync.
- rin  in  3  red; gin  in  3  green; bin  in  2  blue.
- px_valid  out  1  one-cycle strobe per active pixel, only while locked.
- px_x  out  10  pixel column 0..639.
- px_y  out  10  pixel row 0..479.
- px_rgb  out  8  {r,g,b} sampled for this pixel.
- frame_start  out  1  coincides with px_valid of pixel (0,0).
- locked  out  1  timing lock.
- lock_lost  out  1  one-cycle pulse on leaving LOCKED.
- meas_htotal  out  12  last measured line length in clocks.
- meas_vtotal  out  10  last measured frame length in lines.

## Operation
- Inputs registered once (hs_q, vs_q, rgb_q), then again for edge detect; assertion edge = current registered value at SYNC_POL, previous not.
- hcnt (12 b): clears to 0 on hs edge, else increments, saturating at 4095. On hs edge, meas_htotal <= hcnt+1 (saturating); line good iff hcnt == H_TOTAL-1.
- lcnt (10 b): increments on hs edge, saturating at 1023; clears to 0 on vs edge. Same-cycle hs and vs edge: lcnt <= 0 (vs wins); the hs edge is still measured. On vs edge, meas_vtotal <= lcnt; frame good iff lcnt == V_TOTAL and every line measured since the previous vs edge was good.
- Row y active when lcnt == V_START+y, y < V_ACTIVE. Pixel x sampled on the cycle hcnt == H_START + CLKS_PER_PIXEL*x + SAMPLE_PHASE, x < H_ACTIVE.
- FSM: SEARCH (reset): first vs edge -> TRACK, good-frame count = 0. TRACK: good frame increments count; count reaching LOCK_FRAMES -> LOCKED; bad frame clears count, stays TRACK. LOCKED: any bad line, or bad frame -> SEARCH with lock_lost pulse. A bad line is detected immediately on its hs edge, not at frame end.
- locked = (state == LOCKED).

## Timing
- Reset: all outputs 0, state SEARCH, hcnt/lcnt 0, good count 0.
- Sync-edge latency: edge on hs pin at cycle n is acted on (hcnt clear) at cycle n+2.
- px_valid, px_x, px_y, px_rgb, frame_start registered: asserted the cycle after the sample condition; px_rgb is rgb_q of that sample cycle. Outputs hold between strobes.
- Loss of lock takes effect the cycle after the offending edge; px_valid suppressed from that cycle; no partial-frame strobes until relocked.
- Reset mid-frame: returns to SEARCH; requires first vs edge plus LOCK_FRAMES good frames to relock.
- meas_* update the cycle after their edge regardless of state.

## Structure
- Package vga_timing_pkg: 640x480@60 constants (H_TOTAL, V_TOTAL, H_START, V_START, actives, CLKS_PER_PIXEL), FSM state enum {SEARCH, TRACK, LOCKED}; shared with the generator.
- One sub-module: vga_edge_meter (registered sync input, edge detect, saturating period counter, measured-length output), instantiated for hs (counts clk) and vs (counts hs edges).

## Test plan
- Generator looped back, rst released: locked rises after first vs edge + 2 frames; then exactly 307200 px_valid per frame, one frame_start per frame; meas_htotal=3200, meas_vtotal=521.
- Generator test pattern: pixel (250,300) reports px_rgb with red[1]=1, green[0]=0; pixel (100,100) reports green[0]=1.
- One line stretched to 3201 clocks while locked: lock_lost pulse, locked=0, no px_valid for rest of frame, relock after 2 good frames.
- vs held inactive for a frame: lcnt saturates at 1023, no lock; next vs edge reports meas_vtotal=1023 and frame bad.
- rst pulsed at row 240 while locked: all outputs 0 next cycle, SEARCH, relock after vs + 2 frames.
- hs and vs edges forced same cycle: lcnt=0, meas_htotal still updated.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and lock-state encoding for the VGA
// sync generator and the receive-side decoder.
package vga_timing_pkg;

  localparam int H_TOTAL        = 3200;
  localparam int V_TOTAL        = 521;
  localparam int H_START        = 576;
  localparam int V_START        = 31;
  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int CLKS_PER_PIXEL = 4;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } sync_state_e;

endpackage

// File: rtl/vga_edge_meter.sv
// Registers one sync input, detects its assertion edge and measures the period
// between edges with a saturating counter advanced by cnt_en.
module vga_edge_meter #(
  parameter int DATA_W   = 12,
  parameter bit SYNC_POL = 1'b0,
  parameter bit MEAS_INC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_in,
  input  logic              cnt_en,
  output logic              edge_det,
  output logic [DATA_W-1:0] cnt,
  output logic [DATA_W-1:0] meas
);

  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  logic sync_p0;
  logic sync_p1;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == CNT_MAX) ? v : v + DATA_W'(1);
  endfunction

  // p0: pin capture, p1: previous value for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= ~SYNC_POL;
      sync_p1 <= ~SYNC_POL;
    end else begin
      sync_p0 <= sync_in;
      sync_p1 <= sync_p0;
    end
  end

  assign edge_det = (sync_p0 == SYNC_POL) && (sync_p1 != SYNC_POL);

  // Edge restarts the period; the clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      meas <= '0;
    end else if (edge_det) begin
      cnt  <= '0;
      meas <= MEAS_INC ? sat_inc(cnt) : cnt;
    end else if (cnt_en) begin
      cnt  <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: rebuilds pixel coordinates and strobes from
// hs/vs/RGB, measures line/frame length and tracks timing lock.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL        = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL        = vga_timing_pkg::V_TOTAL,
  parameter int H_START        = vga_timing_pkg::H_START,
  parameter int V_START        = vga_timing_pkg::V_START,
  parameter int H_ACTIVE       = vga_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE       = vga_timing_pkg::V_ACTIVE,
  parameter int CLKS_PER_PIXEL = vga_timing_pkg::CLKS_PER_PIXEL,
  parameter int SAMPLE_PHASE   = 2,
  parameter bit SYNC_POL       = 1'b0,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [2:0]  rin,
  input  logic [2:0]  gin,
  input  logic [1:0]  bin,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [7:0]  px_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        lock_lost,
  output logic [11:0] meas_htotal,
  output logic [9:0]  meas_vtotal
);

  localparam int GC_W = $clog2(LOCK_FRAMES + 1);

  logic              hs_edge;
  logic              vs_edge;
  logic [11:0]       hcnt;
  logic [9:0]        lcnt;
  logic [7:0]        rgb_p0;
  logic              line_err;
  logic              line_bad;
  logic              frame_good;
  logic              lost;
  logic              sample;
  logic              h_win;
  logic              v_win;
  logic              phase_hit;
  logic [11:0]       hrel;
  logic [9:0]        vrel;
  logic [9:0]        x_idx;
  logic [GC_W-1:0]   good_cnt;
  logic [GC_W-1:0]   good_cnt_nxt;
  sync_state_e       state;
  sync_state_e       state_nxt;

  vga_edge_meter #(
    .DATA_W   (12),
    .SYNC_POL (SYNC_POL),
    .MEAS_INC (1'b1)
  ) u_hs_meter (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (hs),
    .cnt_en   (1'b1),
    .edge_det (hs_edge),
    .cnt      (hcnt),
    .meas     (meas_htotal)
  );

  // Lines are counted in hs edges; vs registered with the same latency as hs.
  vga_edge_meter #(
    .DATA_W   (10),
    .SYNC_POL (SYNC_POL),
    .MEAS_INC (1'b0)
  ) u_vs_meter (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (vs),
    .cnt_en   (hs_edge),
    .edge_det (vs_edge),
    .cnt      (lcnt),
    .meas     (meas_vtotal)
  );

  // p0: RGB capture aligned with the registered sync inputs
  always_ff @(posedge clk) begin
    rgb_p0 <= {rin, gin, bin};
  end

  assign line_bad   = hs_edge && (hcnt != 12'(H_TOTAL - 1));
  assign frame_good = (lcnt == 10'(V_TOTAL)) && !line_err && !line_bad;

  // A line closed by an hs edge coincident with vs belongs to the ending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_err <= 1'b0;
    end else if (vs_edge) begin
      line_err <= 1'b0;
    end else if (line_bad) begin
      line_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    lost         = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_nxt    = TRACK;
          good_cnt_nxt = '0;
        end
      end
      TRACK: begin
        if (vs_edge) begin
          if (!frame_good) begin
            good_cnt_nxt = '0;
          end else if (good_cnt == GC_W'(LOCK_FRAMES - 1)) begin
            state_nxt    = LOCKED;
            good_cnt_nxt = GC_W'(LOCK_FRAMES);
          end else begin
            good_cnt_nxt = good_cnt + GC_W'(1);
          end
        end
      end
      LOCKED: begin
        if (line_bad || (vs_edge && !frame_good)) begin
          state_nxt    = SEARCH;
          good_cnt_nxt = '0;
          lost         = 1'b1;
        end
      end
      default: begin
        state_nxt    = SEARCH;
        good_cnt_nxt = '0;
      end
    endcase
  end

  assign locked = (state == LOCKED);

  assign hrel      = hcnt - 12'(H_START);
  assign vrel      = lcnt - 10'(V_START);
  assign x_idx     = 10'(hrel / 12'(CLKS_PER_PIXEL));
  assign h_win     = (hcnt >= 12'(H_START)) &&
                     (hcnt <  12'(H_START + CLKS_PER_PIXEL * H_ACTIVE));
  assign v_win     = (lcnt >= 10'(V_START)) && (lcnt < 10'(V_START + V_ACTIVE));
  assign phase_hit = (hrel % 12'(CLKS_PER_PIXEL)) == 12'(SAMPLE_PHASE);
  // Gating on the next state too drops the strobe in the cycle lock is lost.
  assign sample    = h_win && v_win && phase_hit &&
                     (state == LOCKED) && (state_nxt == LOCKED);

  // p1: registered pixel strobe and coordinates, held between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      px_valid    <= 1'b0;
      frame_start <= 1'b0;
      lock_lost   <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
    end else begin
      px_valid    <= sample;
      frame_start <= sample && (x_idx == 10'd0) && (vrel == 10'd0);
      lock_lost   <= lost;
      if (sample) begin
        px_x   <= x_idx;
        px_y   <= vrel;
        px_rgb <= rgb_p0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Loopback bench for vga_sync_decoder on a reduced raster: a behavioural
// generator drives hs/vs/RGB and queues the pixels the decoder must report.
module tb_vga_sync_decoder;

  localparam int HT   = 48;
  localparam int VT   = 12;
  localparam int HS0  = 10;
  localparam int VS0  = 3;
  localparam int HA   = 8;
  localparam int VA   = 6;
  localparam int CPP  = 4;
  localparam int PH   = 2;
  localparam int LF   = 2;
  localparam int HS_W = 4;
  localparam bit SP   = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs;
  logic        vs;
  logic [2:0]  rin;
  logic [2:0]  gin;
  logic [1:0]  bin;
  logic        px_valid;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic [7:0]  px_rgb;
  logic        frame_start;
  logic        locked;
  logic        lock_lost;
  logic [11:0] meas_htotal;
  logic [9:0]  meas_vtotal;

  vga_sync_decoder #(
    .H_TOTAL        (HT),
    .V_TOTAL        (VT),
    .H_START        (HS0),
    .V_START        (VS0),
    .H_ACTIVE       (HA),
    .V_ACTIVE       (VA),
    .CLKS_PER_PIXEL (CPP),
    .SAMPLE_PHASE   (PH),
    .SYNC_POL       (SP),
    .LOCK_FRAMES    (LF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hs          (hs),
    .vs          (vs),
    .rin         (rin),
    .gin         (gin),
    .bin         (bin),
    .px_valid    (px_valid),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_rgb      (px_rgb),
    .frame_start (frame_start),
    .locked      (locked),
    .lock_lost   (lock_lost),
    .meas_htotal (meas_htotal),
    .meas_vtotal (meas_vtotal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] rgb;
    logic       fs;
  } px_t;

  px_t exp_q[$];
  int  n_vec    = 0;
  int  n_err    = 0;
  int  ll_cnt   = 0;
  int  odd_pend = 0;
  px_t got;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int x, input int y);
    return 8'((x * 37 + y * 11 + 5) & 255);
  endfunction

  task automatic chk_zero_outputs();
    chk("rst_px_valid", px_valid, 0);
    chk("rst_px_x", px_x, 0);
    chk("rst_px_y", px_y, 0);
    chk("rst_px_rgb", px_rgb, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_meas_htotal", meas_htotal, 0);
    chk("rst_meas_vtotal", meas_vtotal, 0);
  endtask

  // Monitor: every strobe must match the oldest queued pixel.
  always @(negedge clk) begin
    if (lock_lost) ll_cnt++;
    if (px_valid) begin
      if (exp_q.size() == 0) begin
        chk("px_valid_unexpected", px_valid, 0);
      end else begin
        got = exp_q.pop_front();
        chk("px_x", px_x, got.x);
        chk("px_y", px_y, got.y);
        chk("px_rgb", px_rgb, got.rgb);
        chk("frame_start", frame_start, got.fs);
      end
    end else if (frame_start) begin
      chk("frame_start_stray", frame_start, 0);
    end
  end

  task automatic drive_line(input int len, input int line, input bit push,
                            input int vs_set, input int vs_clr, input int rst_at);
    for (int gh = 0; gh < len; gh++) begin
      @(negedge clk);
      if (rst_at >= 0 && gh == rst_at + 1) chk_zero_outputs();
      hs  = (gh < HS_W) ? SP : ~SP;
      if (gh == vs_set) vs = SP;
      if (gh == vs_clr) vs = ~SP;
      rst = (gh == rst_at);
      if (line >= VS0 && line < VS0 + VA && gh >= HS0 && gh < HS0 + CPP * HA) begin
        int x;
        int y;
        logic [7:0] p;
        px_t e;
        x = (gh - HS0) / CPP;
        y = line - VS0;
        p = pat(x, y);
        {rin, gin, bin} = p;
        if (push && ((gh - HS0) % CPP) == 0) begin
          e.x   = 10'(x);
          e.y   = 10'(y);
          e.rgb = p;
          e.fs  = (x == 0) && (y == 0);
          exp_q.push_back(e);
        end
      end else begin
        {rin, gin, bin} = 8'h00;
      end
    end
  endtask

  task automatic run_frame(input bit exp, input int vs_off, input int odd_line,
                           input int odd_len, input int rst_line);
    bit live;
    live = exp;
    for (int l = 0; l < VT; l++) begin
      if (l == rst_line) live = 1'b0;
      drive_line((l == odd_line) ? odd_len : HT, l, live,
                 (l == 0) ? vs_off : -1, (l == 2) ? vs_off : -1,
                 (l == rst_line) ? 6 : -1);
      if (odd_pend != 0) begin
        chk("meas_htotal_odd", meas_htotal, odd_pend);
        odd_pend = 0;
      end
      if (l == odd_line) begin
        live     = 1'b0;
        odd_pend = odd_len;
      end
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hs  = ~SP;
    vs  = ~SP;
    {rin, gin, bin} = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero_outputs();
    rst = 1'b0;

    // Acquire: first vs edge, then two good frames
    run_frame(1'b0, 20, -1, 0, -1);
    chk("locked_after_f0", locked, 0);
    run_frame(1'b0, 20, -1, 0, -1);
    chk("locked_after_f1", locked, 0);
    run_frame(1'b1, 20, -1, 0, -1);
    chk("locked_f2", locked, 1);
    chk("meas_htotal", meas_htotal, HT);
    chk("meas_vtotal", meas_vtotal, VT);
    run_frame(1'b1, 20, -1, 0, -1);

    // Stretched line in row 1 drops lock at its closing edge
    run_frame(1'b1, 20, 4, HT + 1, -1);
    chk("lock_lost_pulses_1", ll_cnt, 1);
    chk("locked_after_stretch", locked, 0);
    run_frame(1'b0, 20, -1, 0, -1);
    run_frame(1'b0, 20, -1, 0, -1);
    chk("locked_before_relock", locked, 0);

    // Relocked, then reset mid-frame at row 2
    run_frame(1'b1, 20, -1, 0, VS0 + 2);
    chk("locked_after_rst", locked, 0);
    chk("lock_lost_no_pulse_on_rst", ll_cnt, 1);
    run_frame(1'b0, 20, -1, 0, -1);
    run_frame(1'b0, 20, -1, 0, -1);
    chk("locked_before_relock2", locked, 0);
    run_frame(1'b1, 20, -1, 0, -1);
    chk("locked_relock2", locked, 1);
    run_frame(1'b1, 20, -1, 0, -1);

    // Short last line whose closing hs edge coincides with the vs edge
    run_frame(1'b1, 20, VT - 1, HT - 3, -1);
    run_frame(1'b0, 0, -1, 0, -1);
    chk("lock_lost_pulses_2", ll_cnt, 2);
    chk("locked_after_short", locked, 0);
    chk("meas_vtotal_coincident", meas_vtotal, VT - 1);
    run_frame(1'b0, 20, -1, 0, -1);
    chk("meas_vtotal_after_coincident", meas_vtotal, VT);

    // vs withheld: line counter saturates
    for (int i = 0; i < 1030; i++) drive_line(16, 99, 1'b0, -1, -1, -1);
    drive_line(16, 99, 1'b0, 8, -1, -1);
    chk("meas_vtotal_saturated", meas_vtotal, 1023);
    chk("meas_htotal_short", meas_htotal, 16);
    chk("locked_after_saturate", locked, 0);

    repeat (8) @(negedge clk);
    chk("queue_final", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
